pipe_hazard_ctrl: RTL and testbench

//  Central hazard/stall/flush controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and operand-forwarding control for a 5-stage pipeline.
// A not-ready data memory freezes the pipe; the wait FSM forces completion after MEM_TMO cycles.
//
//   state  | meaning
//   S_RUN  | normal flow; a not-ready memory access starts a wait
//   S_WAIT | memory access outstanding, whole pipe frozen
//   S_TMO  | one-cycle forced completion after timeout, pipe advances
module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int BR_STAGE = 3,
  parameter int FWD_EN   = 1,
  parameter int MEM_TMO  = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_rw,
  input  logic             ex_mr,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_rw,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_rw,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             en_if,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_tmo,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_TMO} state_t;

  // Down-counter holds the stalled cycles still allowed; the RUN cycle that
  // starts the wait is the first of the MEM_TMO.
  localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(MEM_TMO - 1);
  localparam logic             BR_MEM   = (BR_STAGE == 3);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmr, tmr_nxt;
  logic             br_pend, br_pend_nxt;
  logic             mem_stall;
  logic             ex_hit, mem_hit, raw_stall;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic             unused_wb;

  // WB writes land first in the regfile, so WB dests never create a hazard.
  assign unused_wb = ^{wb_rd, wb_rw};

  assign ex_hit  = ex_rw && (ex_rd != '0) &&
                   ((id_rs1_use && (id_rs1 == ex_rd)) || (id_rs2_use && (id_rs2 == ex_rd)));
  assign mem_hit = mem_rw && (mem_rd != '0) &&
                   ((id_rs1_use && (id_rs1 == mem_rd)) || (id_rs2_use && (id_rs2 == mem_rd)));
  assign raw_stall = (FWD_EN != 0) ? (ex_hit && ex_mr) : (ex_hit || mem_hit);

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [RA_W-1:0] rs,
                                         input logic ex_w, input logic [RA_W-1:0] ex_d,
                                         input logic mem_w, input logic [RA_W-1:0] mem_d);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && mem_w && (mem_d != '0) && (mem_d == rs)) sel = 2'b10;
    if (use_src && ex_w && (ex_d != '0) && (ex_d == rs))    sel = 2'b01;
    return sel;
  endfunction

  assign fwd_a_nxt = fwd_sel(id_rs1_use, id_rs1, ex_rw, ex_rd, mem_rw, mem_rd);
  assign fwd_b_nxt = fwd_sel(id_rs2_use, id_rs2, ex_rw, ex_rd, mem_rw, mem_rd);

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    br_pend_nxt = br_pend;
    mem_stall   = 1'b0;
    en_if       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;

    case (state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          mem_stall = 1'b1;
          tmr_nxt   = TMR_LOAD;
          state_nxt = (MEM_TMO <= 1) ? S_TMO : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_RUN;
        end else begin
          mem_stall = 1'b1;
          if (tmr == CNT_W'(1)) state_nxt = S_TMO;
          else                  tmr_nxt   = tmr - CNT_W'(1);
        end
      end
      S_TMO:   state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase

    if (mem_stall) begin
      en_if       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      br_pend_nxt = br_pend || br_taken;
    end else begin
      br_pend_nxt = 1'b0;
      if (br_taken || br_pend) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = BR_MEM;
      end else if (raw_stall) begin
        en_if      = 1'b0;
        en_ifid    = 1'b0;
        flush_idex = 1'b1;
      end
    end

    if (rst) begin
      en_if       = 1'b1;
      en_ifid     = 1'b1;
      en_idex     = 1'b1;
      en_exmem    = 1'b1;
      en_memwb    = 1'b1;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      tmr       <= '0;
      br_pend   <= 1'b0;
      mem_tmo   <= 1'b0;
      stall_cnt <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      br_pend <= br_pend_nxt;
      if (state == S_TMO) mem_tmo <= 1'b1;
      if (!en_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((FWD_EN != 0) && en_idex) begin
        fwd_a <= flush_idex ? 2'b00 : fwd_a_nxt;
        fwd_b <= flush_idex ? 2'b00 : fwd_b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven with shared stimulus and
// checked every cycle against a cycle-count model, plus directed literal scenarios.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_use, id_rs2_use, ex_rw, ex_mr, mem_rw, wb_rw;
  logic       br_taken, mem_req, mem_ready;

  wire [7:0]  ctl_a, ctl_b;
  wire [1:0]  fa_a, fb_a, fa_b, fb_b;
  wire        tmo_a, tmo_b;
  wire [15:0] sc_a;
  wire [3:0]  sc_b;

  int  errors = 0;
  int  checks = 0;
  bit  run_chk = 1'b0;
  bit  slow = 1'b0;

  // Instance a: branch in MEM, forwarding, 15-cycle timeout.
  pipe_hazard_ctrl #(.RA_W(5), .BR_STAGE(3), .FWD_EN(1), .MEM_TMO(15), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_mr(ex_mr), .mem_rd(mem_rd), .mem_rw(mem_rw),
    .wb_rd(wb_rd), .wb_rw(wb_rw), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .en_if(ctl_a[7]), .en_ifid(ctl_a[6]), .en_idex(ctl_a[5]), .en_exmem(ctl_a[4]), .en_memwb(ctl_a[3]),
    .flush_ifid(ctl_a[2]), .flush_idex(ctl_a[1]), .flush_exmem(ctl_a[0]),
    .fwd_a(fa_a), .fwd_b(fb_a), .mem_tmo(tmo_a), .stall_cnt(sc_a));

  // Instance b: branch in EX, no forwarding, 4-cycle timeout, 4-bit counter.
  pipe_hazard_ctrl #(.RA_W(5), .BR_STAGE(2), .FWD_EN(0), .MEM_TMO(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_mr(ex_mr), .mem_rd(mem_rd), .mem_rw(mem_rw),
    .wb_rd(wb_rd), .wb_rw(wb_rw), .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .en_if(ctl_b[7]), .en_ifid(ctl_b[6]), .en_idex(ctl_b[5]), .en_exmem(ctl_b[4]), .en_memwb(ctl_b[3]),
    .flush_ifid(ctl_b[2]), .flush_idex(ctl_b[1]), .flush_exmem(ctl_b[0]),
    .fwd_a(fa_b), .fwd_b(fb_b), .mem_tmo(tmo_b), .stall_cnt(sc_b));

  always #5 clk = ~clk;

  // Model state: consecutive stalled cycles, pending timeout cycle, etc.
  int         run_len[2];
  bit         tmo_now[2], pend[2], tflag[2];
  int         scnt[2];
  logic [1:0] mfa[2], mfb[2];

  function automatic int tlim(int k);  return (k == 0) ? 15 : 4;     endfunction
  function automatic int smax(int k);  return (k == 0) ? 65535 : 15; endfunction

  function automatic bit uses(logic [4:0] r);
    return (id_rs1_use && id_rs1 == r) || (id_rs2_use && id_rs2 == r);
  endfunction

  function automatic bit hazard(int k);
    bit exm, mm;
    exm = ex_rw && (ex_rd != 0) && uses(ex_rd);
    mm  = mem_rw && (mem_rd != 0) && uses(mem_rd);
    if (k == 0) return exm && ex_mr;
    return exm || mm;
  endfunction

  function automatic logic [1:0] src(bit u, logic [4:0] r);
    if (!u) return 2'd0;
    if (ex_rw && ex_rd != 0 && ex_rd == r) return 2'd1;
    if (mem_rw && mem_rd != 0 && mem_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  // {en_if,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex,flush_exmem}
  function automatic logic [7:0] exp_ctl(int k, output bit ms);
    ms = 1'b0;
    if (rst) return 8'hF8;
    if (tmo_now[k])        ms = 1'b0;
    else if (run_len[k] > 0) ms = !mem_ready;
    else                   ms = mem_req && !mem_ready;
    if (ms) return 8'h00;
    if (br_taken || pend[k]) return (k == 0) ? 8'hFF : 8'hFE;
    if (hazard(k)) return 8'b0011_1010;
    return 8'hF8;
  endfunction

  task automatic model_step(int k);
    logic [7:0] c;
    bit ms;
    c = exp_ctl(k, ms);
    if (rst) begin
      run_len[k] = 0; tmo_now[k] = 0; pend[k] = 0; tflag[k] = 0;
      scnt[k] = 0; mfa[k] = 2'd0; mfb[k] = 2'd0;
    end else begin
      if (!c[7] && scnt[k] < smax(k)) scnt[k]++;
      if (tmo_now[k]) begin
        tflag[k] = 1; tmo_now[k] = 0;
      end else if (ms) begin
        run_len[k]++;
        if (run_len[k] == tlim(k)) begin run_len[k] = 0; tmo_now[k] = 1; end
      end else begin
        run_len[k] = 0;
      end
      pend[k] = ms ? (pend[k] || br_taken) : 1'b0;
      if (k == 0 && c[5]) begin
        mfa[k] = c[1] ? 2'd0 : src(id_rs1_use, id_rs1);
        mfb[k] = c[1] ? 2'd0 : src(id_rs2_use, id_rs2);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] c;
    bit ms;
    if (run_chk) begin
      c = exp_ctl(0, ms);
      chk("a.ctl", ctl_a, c);
      chk("a.fwd_a", fa_a, mfa[0]);
      chk("a.fwd_b", fb_a, mfb[0]);
      chk("a.mem_tmo", tmo_a, tflag[0]);
      chk("a.stall_cnt", sc_a, scnt[0]);
      c = exp_ctl(1, ms);
      chk("b.ctl", ctl_b, c);
      chk("b.fwd", {fa_b, fb_b}, 4'b0000);
      chk("b.mem_tmo", tmo_b, tflag[1]);
      chk("b.stall_cnt", sc_b, scnt[1]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 0; mem_rw = 0; wb_rd = 0; wb_rw = 0;
    br_taken = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic do_reset;
    rst = 1; idle(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    tick();
    run_chk = 1'b1;
    rst = 0;

    // Reset state
    at_neg();
    chk("rst.ctl", ctl_a, 8'hF8);
    chk("rst.fwd", {fa_a, fb_a}, 4'b0000);
    chk("rst.tmo", tmo_a, 0);
    chk("rst.cnt", sc_a, 0);
    tick();

    // addi x5 ; add x6,x5,x5
    do_reset();
    ex_rd = 5; ex_rw = 1; id_rs1 = 5; id_rs2 = 5; id_rs1_use = 1; id_rs2_use = 1;
    at_neg();
    chk("t1.a_no_stall", ctl_a, 8'hF8);
    chk("t1.b_raw_stall", ctl_b, 8'b0011_1010);
    tick(); idle();
    at_neg();
    chk("t1.fwd", {fa_a, fb_a}, 4'b0101);
    chk("t1.cnt", sc_a, 0);
    tick();

    // lw x5 ; add x6,x5,x1
    do_reset();
    ex_rd = 5; ex_rw = 1; ex_mr = 1; id_rs1 = 5; id_rs2 = 1; id_rs1_use = 1; id_rs2_use = 1;
    at_neg();
    chk("t2.load_use", ctl_a, 8'b0011_1010);
    tick();
    ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 5; mem_rw = 1;
    at_neg();
    chk("t2.release", ctl_a, 8'hF8);
    tick(); idle();
    at_neg();
    chk("t2.fwd", {fa_a, fb_a}, 4'b1000);
    chk("t2.cnt", sc_a, 1);
    tick();

    // Branch flush
    do_reset();
    br_taken = 1;
    at_neg();
    chk("t3.a_flush", ctl_a, 8'hFF);
    chk("t3.b_flush", ctl_b, 8'hFE);
    tick(); idle();
    at_neg();
    chk("t3.one_cycle", ctl_a, 8'hF8);
    tick();

    // Memory stall with a branch arriving mid-stall
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      mem_req = 1; mem_ready = 0; br_taken = (i == 2);
      at_neg();
      chk("t4.stall", ctl_a, 8'h00);
      tick();
    end
    br_taken = 0; mem_req = 1; mem_ready = 1;
    at_neg();
    chk("t4.a_pend_flush", ctl_a, 8'hFF);
    chk("t4.b_tmo_flush", ctl_b, 8'hFE);
    tick(); idle();
    at_neg();
    chk("t4.after", ctl_a, 8'hF8);
    chk("t4.cnt", sc_a, 4);
    chk("t4.b_tmo", tmo_b, 1);
    tick();

    // Timeout, then reset while waiting
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 15; i++) begin
      at_neg();
      chk("t5.stall", ctl_a, 8'h00);
      tick();
    end
    at_neg();
    chk("t5.tmo_adv", ctl_a, 8'hF8);
    chk("t5.tmo_not_yet", tmo_a, 0);
    tick(); idle();
    at_neg();
    chk("t5.tmo_set", tmo_a, 1);
    chk("t5.cnt", sc_a, 15);
    tick();
    at_neg();
    chk("t5.tmo_sticky", tmo_a, 1);
    tick();
    mem_req = 1; mem_ready = 0;
    tick(); tick(); tick();
    rst = 1;
    at_neg();
    chk("t6.rst_outputs", ctl_a, 8'hF8);
    tick();
    rst = 0; idle(); mem_ready = 0;
    at_neg();
    chk("t6.run", ctl_a, 8'hF8);
    chk("t6.tmo", tmo_a, 0);
    chk("t6.cnt", sc_a, 0);
    tick();

    // FWD_EN=0: RAW stall until writer reaches WB
    do_reset();
    ex_rd = 5; ex_rw = 1; id_rs1 = 5; id_rs2 = 5; id_rs1_use = 1; id_rs2_use = 1;
    at_neg();
    chk("t7.stall1", ctl_b, 8'b0011_1010);
    tick();
    ex_rd = 0; ex_rw = 0; mem_rd = 5; mem_rw = 1;
    at_neg();
    chk("t7.stall2", ctl_b, 8'b0011_1010);
    tick();
    mem_rd = 0; mem_rw = 0; wb_rd = 5; wb_rw = 1;
    at_neg();
    chk("t7.go", ctl_b, 8'hF8);
    tick(); idle();
    at_neg();
    chk("t7.cnt", sc_b, 2);
    tick();

    // x0 and unqualified sources never match
    do_reset();
    ex_rd = 0; ex_rw = 1; ex_mr = 1; mem_rd = 0; mem_rw = 1;
    id_rs1 = 0; id_rs2 = 0; id_rs1_use = 1; id_rs2_use = 1;
    at_neg();
    chk("x0.a", ctl_a, 8'hF8);
    chk("x0.b", ctl_b, 8'hF8);
    tick();
    ex_rd = 3; ex_rw = 0; id_rs1 = 3;
    at_neg();
    chk("norw.a", ctl_a, 8'hF8);
    tick();
    ex_rw = 1; id_rs1_use = 0; id_rs2_use = 0;
    at_neg();
    chk("nouse.b", ctl_b, 8'hF8);
    tick();

    // Stall counter saturation on the 4-bit instance
    do_reset();
    ex_rd = 5; ex_rw = 1; id_rs1 = 5; id_rs1_use = 1;
    repeat (20) tick();
    idle();
    at_neg();
    chk("sat.b", sc_b, 15);
    chk("sat.a", sc_a, 0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) slow = !slow;
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_rs1_use = ($urandom_range(0, 3) != 0);
      id_rs2_use = ($urandom_range(0, 3) != 0);
      ex_rd      = 5'($urandom_range(0, 3));
      ex_rw      = ($urandom_range(0, 1) != 0);
      ex_mr      = ($urandom_range(0, 2) == 0);
      mem_rd     = 5'($urandom_range(0, 3));
      mem_rw     = ($urandom_range(0, 1) != 0);
      wb_rd      = 5'($urandom_range(0, 3));
      wb_rw      = ($urandom_range(0, 1) != 0);
      br_taken   = ($urandom_range(0, 9) == 0);
      mem_req    = ($urandom_range(0, 2) == 0);
      mem_ready  = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end

    rst = 0; idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
